// File: rtl/minmax_pkg.sv
// Shared state/mode encodings and counter helper for the streaming min/max reduction engine.
package minmax_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;
  localparam logic MODE_UNS = 1'b0;
  localparam logic MODE_SGN = 1'b1;

  // All-ones value of a w-bit counter; callers truncate to their own width.
  function automatic logic [63:0] cnt_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/gt_int_nbit.sv
// WIDTH-bit greater-than comparator; signed mode biases both MSBs so an unsigned compare suffices.
module gt_int_nbit
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;

  always_comb begin
    a_m = a;
    b_m = b;
    if (is_signed == MODE_SGN) begin
      a_m[WIDTH-1] = ~a[WIDTH-1];
      b_m[WIDTH-1] = ~b[WIDTH-1];
    end
    gt = a_m > b_m;
  end

endmodule

// File: rtl/minmax_reduce_nbit.sv
// Streaming frame min/max reduction with element count; winner index port exists only when
// MINMAX_ARGIDX_EN is defined.
module minmax_reduce_nbit
  import minmax_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode_min,
  input  logic             mode_signed,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MINMAX_ARGIDX_EN
  output logic [CNT_W-1:0] out_idx,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             min_q, min_d;
  logic             sgn_q, sgn_d;
  logic             ready_q;
  logic             beat;
  logic             better;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
`ifdef MINMAX_ARGIDX_EN
  logic [CNT_W-1:0] idx_q, idx_d;
`endif

  // Swapping operands turns the single greater-than into a less-than for min mode.
  assign cmp_a = (min_q == MODE_MIN) ? acc_q   : in_data;
  assign cmp_b = (min_q == MODE_MIN) ? in_data : acc_q;

  gt_int_nbit #(
    .WIDTH (WIDTH)
  ) u_gt (
    .a         (cmp_a),
    .b         (cmp_b),
    .is_signed (sgn_q),
    .gt        (better)
  );

  assign beat = in_valid & ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    min_d   = min_q;
    sgn_d   = sgn_q;
`ifdef MINMAX_ARGIDX_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          acc_d   = in_data;
          min_d   = mode_min;
          sgn_d   = mode_signed;
          count_d = CNT_W'(1);
`ifdef MINMAX_ARGIDX_EN
          idx_d   = '0;
`endif
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          // count equals the zero-based position of the incoming beat (saturating)
          if (better) begin
            acc_d = in_data;
`ifdef MINMAX_ARGIDX_EN
            idx_d = count_q;
`endif
          end
          if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
          end
          if (in_last) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      min_q   <= MODE_MAX;
      sgn_q   <= MODE_UNS;
      ready_q <= 1'b0;
`ifdef MINMAX_ARGIDX_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      min_q   <= min_d;
      sgn_q   <= sgn_d;
      ready_q <= (state_d != ST_HOLD);
`ifdef MINMAX_ARGIDX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = acc_q;
  assign out_count = count_q;
`ifdef MINMAX_ARGIDX_EN
  assign out_idx   = idx_q;
`endif

endmodule

// File: tb/tb_minmax_reduce_nbit.sv
// Directed table-driven bench for minmax_reduce_nbit (64-bit instance plus a CNT_W=4 instance).
module tb_minmax_reduce_nbit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, mode_min, mode_signed, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] out_count;
`ifdef MINMAX_ARGIDX_EN
  logic [15:0] out_idx;
`endif

  logic       s_in_valid, s_in_last, s_out_ready;
  logic [7:0] s_in_data;
  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [3:0] s_out_count;
`ifdef MINMAX_ARGIDX_EN
  logic [3:0] s_out_idx;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  minmax_reduce_nbit #(.WIDTH(64), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .mode_min    (mode_min),
    .mode_signed (mode_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef MINMAX_ARGIDX_EN
    .out_idx     (out_idx),
`endif
    .out_data    (out_data),
    .out_count   (out_count)
  );

  minmax_reduce_nbit #(.WIDTH(8), .CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (s_in_valid),
    .in_ready    (s_in_ready),
    .in_data     (s_in_data),
    .in_last     (s_in_last),
    .mode_min    (1'b0),
    .mode_signed (1'b0),
    .out_valid   (s_out_valid),
    .out_ready   (s_out_ready),
`ifdef MINMAX_ARGIDX_EN
    .out_idx     (s_out_idx),
`endif
    .out_data    (s_out_data),
    .out_count   (s_out_count)
  );

  typedef struct {
    string       name;
    int          n;
    logic [63:0] d [4];
    logic        mn;
    logic        sg;
    logic [63:0] exp_data;
    logic [15:0] exp_cnt;
    logic [15:0] exp_idx;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Later beats drive inverted mode bits, which the DUT must ignore.
  task automatic send_beat(input logic [63:0] d, input logic last, input logic mn, input logic sg);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_last = last; mode_min = mn; mode_signed = sg;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"umax_tie", 4, '{64'd5, 64'd9, 64'd9, 64'd3}, 1'b0, 1'b0, 64'd9, 16'd4, 16'd1};
    vecs[1] = '{"smin", 3, '{64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0},
                1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 16'd3, 16'd1};
    vecs[2] = '{"umin", 3, '{64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0},
                1'b1, 1'b0, 64'd1, 16'd3, 16'd0};
    vecs[3] = '{"single", 1, '{64'hA5, 64'd0, 64'd0, 64'd0}, 1'b0, 1'b0, 64'hA5, 16'd1, 16'd0};
    vecs[4] = '{"smax", 3, '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h10, 64'd0},
                1'b0, 1'b1, 64'h10, 16'd3, 16'd2};
    vecs[5] = '{"umax_modeign", 3, '{64'd3, 64'd8, 64'd1, 64'd0}, 1'b0, 1'b0, 64'd8, 16'd3, 16'd1};
    vecs[6] = '{"umin_tie", 4, '{64'd4, 64'd4, 64'd6, 64'd4}, 1'b1, 1'b0, 64'd4, 16'd4, 16'd0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; mode_min = 1'b0;
    mode_signed = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_count", {48'd0, out_count}, 64'd0);
`ifdef MINMAX_ARGIDX_EN
    chk("rst_out_idx", {48'd0, out_idx}, 64'd0);
`endif
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        send_beat(vecs[i].d[j], j == vecs[i].n - 1,
                  (j == 0) ? vecs[i].mn : ~vecs[i].mn, (j == 0) ? vecs[i].sg : ~vecs[i].sg);
      end
      chk({vecs[i].name, "_valid"}, {63'd0, out_valid}, 64'd1);
      chk({vecs[i].name, "_data"}, out_data, vecs[i].exp_data);
      chk({vecs[i].name, "_count"}, {48'd0, out_count}, {48'd0, vecs[i].exp_cnt});
`ifdef MINMAX_ARGIDX_EN
      chk({vecs[i].name, "_idx"}, {48'd0, out_idx}, {48'd0, vecs[i].exp_idx});
`endif
      release_out();
      chk({vecs[i].name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    end

    // Single beat with out_ready held high: exactly one HOLD cycle then a new frame.
    out_ready = 1'b1;
    send_beat(64'hA5, 1'b1, 1'b0, 1'b0);
    chk("gap_hold_valid", {63'd0, out_valid}, 64'd1);
    chk("gap_hold_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("gap_idle_ready", {63'd0, in_ready}, 64'd1);
    chk("gap_idle_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b0;
    send_beat(64'h3C, 1'b1, 1'b0, 1'b0);
    chk("gap_next_valid", {63'd0, out_valid}, 64'd1);
    chk("gap_next_data", out_data, 64'h3C);
    release_out();

    // Backpressure: result must hold steady while out_ready stays low.
    send_beat(64'd1, 1'b0, 1'b0, 1'b0);
    send_beat(64'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_data", out_data, 64'd2);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      step();
    end
    release_out();
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    send_beat(64'h77, 1'b1, 1'b0, 1'b0);
    chk("bp_next_data", out_data, 64'h77);
    release_out();

    // Reset mid-frame, then a stalled two-beat frame.
    send_beat(64'd100, 1'b0, 1'b0, 1'b0);
    send_beat(64'd300, 1'b0, 1'b0, 1'b0);
    send_beat(64'd200, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_data", out_data, 64'd0);
    chk("mid_rst_count", {48'd0, out_count}, 64'd0);
    step();
    chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
    send_beat(64'd7, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("stall_no_valid", {63'd0, out_valid}, 64'd0);
    send_beat(64'd2, 1'b1, 1'b1, 1'b1);
    chk("after_rst_data", out_data, 64'd7);
    chk("after_rst_count", {48'd0, out_count}, 64'd2);
    release_out();

    // Counter saturation: 20 beats, largest at zero-based position 17.
    for (int j = 0; j < 20; j++) begin
      s_in_valid = 1'b1;
      s_in_data  = (j == 17) ? 8'hF0 : 8'(j);
      s_in_last  = (j == 19);
      if (!s_in_ready) chk("sat_ready", {63'd0, s_in_ready}, 64'd1);
      step();
    end
    s_in_valid = 1'b0; s_in_last = 1'b0;
    chk("sat_valid", {63'd0, s_out_valid}, 64'd1);
    chk("sat_data", {56'd0, s_out_data}, 64'hF0);
    chk("sat_count", {60'd0, s_out_count}, 64'd15);
`ifdef MINMAX_ARGIDX_EN
    chk("sat_idx", {60'd0, s_out_idx}, 64'd15);
`endif
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    chk("sat_valid_drop", {63'd0, s_out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/minmax_reduce_nbit.md
# minmax_reduce_nbit

Streaming min/max reduction engine generalising the single-pair unsigned max benchmark. It accepts a frame of WIDTH-bit elements one per cycle over a valid/ready handshake and returns the frame's maximum or minimum, signed or unsigned. It also returns the element count and, optionally, the position of the winner. It sits behind PIM row readout as a reduction stage and reuses the n-bit greater-than comparator as its datapath core.

## Interface
- WIDTH, 64, element width in bits (≥2)
- CNT_W, 16, width of element counter / index
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  WIDTH  element
- in_last  in  1  element is the last of its frame
- mode_min  in  1  0 = max, 1 = min; sampled on the frame's first accepted beat
- mode_signed  in  1  0 = unsigned, 1 = two's complement; sampled on the first beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  winning element
- out_count  out  CNT_W  elements in frame, saturating
- out_idx  out  CNT_W  zero-based index of the winner; present only with MINMAX_ARGIDX_EN

## Operation
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
- Beat accepted = in_valid & in_ready. in_ready = 1 in IDLE and ACCUM, and 0 in HOLD and during rst.
- IDLE + beat: load acc ← in_data, latch mode_min/mode_signed, count ← 1, idx ← 0, pos ← 1.
  - If in_last is also set, go to HOLD. Otherwise go to ACCUM.
- ACCUM + beat: compute better = mode_min ? (acc > in_data) : (in_data > acc), using the latched mode.
  - If better, acc ← in_data and idx ← pos.
  - count and pos increment, saturating at 2^CNT_W−1. Once saturated, pos stays and index tracking continues with the saturated value.
  - If in_last, go to HOLD.
- Ties never replace acc, so the earliest occurrence wins.
- Signed compare: invert the MSB of both operands, then compare unsigned. No width extension.
- HOLD: out_valid = 1 and out_data/out_count/out_idx are stable. On out_ready, go to IDLE.
- mode inputs are ignored on all beats except the first of a frame.
- rst in any state returns to IDLE, discards any partial frame, and zeroes acc/count/idx.

## Timing
- Reset values: in_ready 0 while rst is high and 1 the cycle after rst falls. out_valid 0; out_data, out_count and out_idx are 0.
- Throughput: one element per cycle within a frame, with no bubbles.
- Latency: last beat accepted at edge t gives out_valid = 1 after edge t.
- Frame gap: at least one cycle (HOLD) between a frame's last beat and the next frame's first beat. This is exactly one cycle if out_ready is held high.
- out_valid stays asserted with stable data until out_ready is sampled high. out_valid falls on the following edge.
- in_valid low mid-frame stalls ACCUM with state unchanged. There is no timeout.
- Outputs are registered. There is no combinational in→out path. in_ready depends only on state.

## Configuration
- MINMAX_ARGIDX_EN defined: the idx register and out_idx port exist, carrying the first-occurrence winner index.
- Not defined: the out_idx port and the idx register are removed. All other behaviour and timing are identical.

## Structure
- Shared package minmax_pkg holds:
  - state enum (IDLE, ACCUM, HOLD)
  - mode bit encodings (MODE_MAX/MODE_MIN, MODE_UNS/MODE_SGN)
  - saturation helper constant CNT_MAX = {CNT_W{1'b1}}
- One sub-module: gt_int_nbit, a parametrised WIDTH comparator with a signed-select input, built on the existing unsigned n-bit greater-than.
  - It is instantiated once, with operands swapped by mode_min.

## Test plan
- WIDTH=64, unsigned max, frame {5, 9, 9, 3} → out_data 9, out_count 4, out_idx 1, out_valid one cycle after the last beat.
- Signed min, frame {0x0000_0000_0000_0001, 0xFFFF_FFFF_FFFF_FFFE, 0x7FFF_FFFF_FFFF_FFFF} → out_data 0xFFFF…FFFE (−2), out_idx 1. The same frame in unsigned min → 1, idx 0.
- Single-beat frame (in_valid & in_last on first beat) with value 0xA5 → out_data 0xA5, count 1, idx 0. A new frame is accepted after one HOLD cycle with out_ready=1.
- Backpressure: out_ready held 0 for 5 cycles → out_valid and data stable, in_ready 0 throughout. Release accepts next frame the following cycle.
- rst pulsed mid-frame after 3 beats → next cycle in IDLE with outputs 0. A subsequent frame {7, 2} max gives 7, count 2.
- CNT_W=4, 20-beat max frame with the largest value at beat 18 → out_count 15 (saturated), out_idx 15.
